// File: rtl/weight_tile_loader.sv
// Weight tile loader: streams weight rows from DRAM into the weight FIFO while
// keeping FIFO occupancy plus in-flight reads within the FIFO capacity.
module weight_tile_loader #(
  parameter int          ROWS_PER_TILE   = 3,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [23:0] ROW_STRIDE      = 24'h8,
  parameter logic [23:0] BANK_OFFSET     = 24'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [7:0]  num_tiles,
  input  logic        buf_sel,
  input  logic        abort,
  output logic        mem_rd_req,
  output logic [23:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic        mem_rd_valid,
  input  logic [63:0] mem_rd_data,
  output logic        wt_fifo_wr,
  output logic [63:0] wt_fifo_data,
  input  logic        wt_pop,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam int CW = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [9:0]      r_total;
  logic [9:0]      r_issued;
  logic [9:0]      r_received;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_occupancy;
  logic [23:0]     r_addr;
  logic            r_req;
  logic            r_wr;
  logic [63:0]     r_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_aborted;

  logic [9:0]      w_tile_rows;
  logic [9:0]      w_total_next;
  logic [9:0]      w_issued_next;
  logic [9:0]      w_received_next;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_occ_next;
  logic [CW-1:0]   w_credits_next;
  logic [23:0]     w_addr_next;
  logic            w_launch;
  logic            w_accept;
  logic            w_resp;
  logic            w_pop;
  logic            w_push_next;
  logic            w_req_next;

  always_comb begin
    w_tile_rows     = 10'(num_tiles) * 10'(ROWS_PER_TILE);
    w_launch        = (r_state == S_IDLE) && start;
    w_accept        = r_req && mem_rd_ready;
    // Responses with nothing in flight are stray and must not disturb the counters.
    w_resp          = mem_rd_valid && (r_outstanding != '0);
    w_pop           = wt_pop && (r_occupancy != '0);
    w_out_next      = r_outstanding + CW'(w_accept) - CW'(w_resp);
    w_occ_next      = r_occupancy + CW'(r_wr) - CW'(w_pop);
    w_push_next     = w_resp && (r_state == S_RUN) && !abort;
    w_total_next    = w_launch ? w_tile_rows : r_total;
    w_issued_next   = w_launch ? 10'd0 : r_issued + 10'(w_accept);
    w_received_next = w_launch ? 10'd0 : r_received + 10'(w_resp);

    w_addr_next = r_addr;
    if (w_launch) begin
      w_addr_next = base_addr + (buf_sel ? BANK_OFFSET : 24'h0);
    end else if (w_accept) begin
      w_addr_next = r_addr + ROW_STRIDE;
    end

    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (w_tile_rows != 10'd0) ? S_RUN : S_FINISH;
        end
      end
      S_RUN: begin
        // r_received reaches the total in the same cycle the last row is pushed.
        if (abort) begin
          w_state_next = S_DRAIN;
        end else if (r_received == r_total) begin
          w_state_next = S_FINISH;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == '0) begin
          w_state_next = S_FINISH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A row captured but not yet pushed still holds a FIFO credit.
    w_credits_next = w_occ_next + w_out_next + CW'(w_push_next);
    w_req_next     = (w_state_next == S_RUN)
                   && (w_issued_next < w_total_next)
                   && (w_out_next < CW'(MAX_OUTSTANDING))
                   && (w_credits_next < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_total       <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_occupancy   <= '0;
      r_addr        <= '0;
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_wdata       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_total       <= w_total_next;
      r_issued      <= w_issued_next;
      r_received    <= w_received_next;
      r_outstanding <= w_out_next;
      r_occupancy   <= w_occ_next;
      r_addr        <= w_addr_next;
      r_req         <= w_req_next;
      r_wr          <= w_push_next;
      if (w_push_next) begin
        r_wdata <= mem_rd_data;
      end
      r_busy        <= (w_state_next != S_IDLE);
      r_done        <= (w_state_next == S_FINISH);
      r_aborted     <= (r_state == S_DRAIN) && (w_state_next == S_FINISH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_occupancy + r_outstanding <= CW'(FIFO_DEPTH));
    end
  end

  assign mem_rd_req   = r_req;
  assign mem_rd_addr  = r_addr;
  assign wt_fifo_wr   = r_wr;
  assign wt_fifo_data = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: a DRAM model answers accepted reads,
// monitors compare addresses, pushes and completions against queued expectations.
module tb_weight_tile_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] base_addr;
  logic [7:0]  num_tiles;
  logic        buf_sel;
  logic        abort;
  logic        mem_rd_req;
  logic [23:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_data;
  logic        wt_fifo_wr;
  logic [63:0] wt_fifo_data;
  logic        wt_pop;
  logic        busy;
  logic        done;
  logic        aborted;

  always #5 clk = ~clk;

  weight_tile_loader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_tiles(num_tiles), .buf_sel(buf_sel), .abort(abort),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .wt_fifo_wr(wt_fifo_wr), .wt_fifo_data(wt_fifo_data), .wt_pop(wt_pop),
    .busy(busy), .done(done), .aborted(aborted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 2;
  int n_acc    = 0;
  int n_push   = 0;

  logic [23:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic        exp_done[$];
  logic [23:0] pend_addr[$];
  int          pend_due[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mdata(input logic [23:0] a);
    return {8'hD0, a, 8'h5A, ~a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // DRAM model: in-order responses, lat cycles after acceptance
  always @(negedge clk) begin
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = mdata(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = 64'h0;
    end
  end

  // Monitor: sampled mid-cycle, after the negedge drivers have settled
  always begin
    @(negedge clk);
    #1;
    if (mem_rd_req && mem_rd_ready) begin
      n_acc++;
      pend_addr.push_back(mem_rd_addr);
      pend_due.push_back(cyc + lat);
      $display("req  addr=%06h", mem_rd_addr);
      chk("req_expected", 64'(exp_addr.size() != 0), 64'(1));
      if (exp_addr.size() != 0) chk("req_addr", 64'(mem_rd_addr), 64'(exp_addr.pop_front()));
    end
    if (wt_fifo_wr) begin
      n_push++;
      $display("push data=%016h", wt_fifo_data);
      chk("push_expected", 64'(exp_data.size() != 0), 64'(1));
      if (exp_data.size() != 0) chk("push_data", wt_fifo_data, exp_data.pop_front());
    end
    if (done) begin
      $display("done aborted=%0b", aborted);
      chk("done_expected", 64'(exp_done.size() != 0), 64'(1));
      if (exp_done.size() != 0) chk("done_aborted", 64'(aborted), 64'(exp_done.pop_front()));
    end
  end

  task automatic launch(input logic [23:0] b, input logic [7:0] t, input logic s);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_tiles = t; buf_sel = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_rows(input logic [23:0] first, input int n, input logic with_data);
    logic [23:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      if (with_data) exp_data.push_back(mdata(a));
      a = a + 24'h8;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_done.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk({name, "_finished"}, 64'(k < 200), 64'(1));
  endtask

  task automatic wait_accepts(input int target, input string name);
    int k;
    k = 0;
    while (n_acc < target && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk({name, "_accepts_seen"}, 64'(k < 100), 64'(1));
  endtask

  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while (pend_due.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_mem_quiet"}, 64'(k < 100), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_all;
    @(negedge clk);
    wt_pop = 1'b1;
    repeat (8) @(negedge clk);
    wt_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_tiles = '0; buf_sel = 1'b0;
    abort = 1'b0; mem_rd_ready = 1'b1; wt_pop = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",  64'(mem_rd_req), 64'(0));
    chk("rst_addr", 64'(mem_rd_addr), 64'(0));
    chk("rst_wr",   64'(wt_fifo_wr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    // stray response with nothing outstanding, plus pops on an empty FIFO
    pend_addr.push_back(24'hABCDEF);
    pend_due.push_back(cyc);
    wt_pop = 1'b1;
    repeat (3) @(negedge clk);
    wt_pop = 1'b0;
    #1;
    chk("stray_busy", 64'(busy), 64'(0));

    // Test 1: one tile from 0x100; a second start while busy is ignored
    p0 = n_push;
    expect_rows(24'h000100, 3, 1'b1);
    exp_done.push_back(1'b0);
    launch(24'h000100, 8'd1, 1'b0);
    launch(24'h000900, 8'd5, 1'b1);
    wait_done("t1");
    chk("t1_pushes", 64'(n_push - p0), 64'(3));
    pop_all();

    // Test 2: zero tiles -> done and busy for exactly one cycle, no requests
    a0 = n_acc;
    exp_done.push_back(1'b0);
    launch(24'h000700, 8'd0, 1'b0);
    #1;
    chk("t2_busy_n1", 64'(busy), 64'(1));
    chk("t2_done_n1", 64'(done), 64'(1));
    chk("t2_req_n1",  64'(mem_rd_req), 64'(0));
    @(negedge clk);
    #1;
    chk("t2_busy_n2", 64'(busy), 64'(0));
    chk("t2_done_n2", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    chk("t2_no_reqs", 64'(n_acc - a0), 64'(0));

    // Test 3: credit limit of 4 with no pops, then a single pop frees one credit
    a0 = n_acc;
    expect_rows(24'h000300, 6, 1'b1);
    exp_done.push_back(1'b0);
    launch(24'h000300, 8'd2, 1'b0);
    repeat (25) @(negedge clk);
    chk("t3_stall_accepts", 64'(n_acc - a0), 64'(4));
    chk("t3_stall_busy", 64'(busy), 64'(1));
    wt_pop = 1'b1;
    @(negedge clk);
    wt_pop = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_one_more", 64'(n_acc - a0), 64'(5));
    wt_pop = 1'b1;
    wait_done("t3");
    wt_pop = 1'b0;
    pop_all();

    // Test 4: upper bank with 24-bit address wrap
    exp_addr.push_back(24'h007FF8);
    exp_addr.push_back(24'h008000);
    exp_addr.push_back(24'h008008);
    exp_data.push_back(mdata(24'h007FF8));
    exp_data.push_back(mdata(24'h008000));
    exp_data.push_back(mdata(24'h008008));
    exp_done.push_back(1'b0);
    launch(24'hFFFFF8, 8'd1, 1'b1);
    wait_done("t4");
    pop_all();

    // Test 5: abort in IDLE ignored; abort with two reads in flight
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("t5_idle_abort_busy", 64'(busy), 64'(0));
    lat = 6;
    a0 = n_acc;
    p0 = n_push;
    expect_rows(24'h000200, 2, 1'b0);
    exp_done.push_back(1'b1);
    launch(24'h000200, 8'd1, 1'b0);
    wait_accepts(a0 + 2, "t5");
    @(negedge clk);
    mem_rd_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("t5");
    chk("t5_accepts", 64'(n_acc - a0), 64'(2));
    chk("t5_pushes",  64'(n_push - p0), 64'(0));
    mem_rd_ready = 1'b1;
    wait_quiet("t5");

    // Test 6: reset mid-run, late responses dropped, clean restart
    a0 = n_acc;
    p0 = n_push;
    expect_rows(24'h000400, 2, 1'b0);
    launch(24'h000400, 8'd2, 1'b0);
    wait_accepts(a0 + 2, "t6");
    @(negedge clk);
    mem_rd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_req",  64'(mem_rd_req), 64'(0));
    mem_rd_ready = 1'b1;
    wait_quiet("t6");
    chk("t6_late_pushes", 64'(n_push - p0), 64'(0));
    lat = 2;
    p0 = n_push;
    expect_rows(24'h000500, 3, 1'b1);
    exp_done.push_back(1'b0);
    launch(24'h000500, 8'd1, 1'b0);
    wait_done("t6_restart");
    chk("t6_restart_pushes", 64'(n_push - p0), 64'(3));
    pop_all();

    chk("left_addr", 64'(exp_addr.size()), 64'(0));
    chk("left_data", 64'(exp_data.size()), 64'(0));
    chk("left_done", 64'(exp_done.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
